// File: rtl/ula_flag_stage_if.sv
// Handshake and payload bundle between the ULA, this flag stage and writeback.
// The slave modport is the stage itself; master is the environment driving it.
interface ula_flag_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [4:0]       in_opcode;
    logic [WIDTH-1:0] in_result;
    logic             in_flag_we;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [3:0]       flags_q;

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_result, in_flag_we, out_ready,
        output in_ready, out_valid, out_result, out_flags, flags_q
    );

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_result, in_flag_we, out_ready,
        input  in_ready, out_valid, out_result, out_flags, flags_q
    );
endinterface

// File: rtl/ula_flag_stage.sv
// Execute-to-writeback stage: derives Z/N/C/V for each ULA result, buffers up to
// two entries in a skid buffer and commits flags when writeback accepts an entry.
module ula_flag_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_flag_stage_if.slave  bus
);
    // State encoding doubles as the buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic             in_ready_q;
    logic [3:0]       flags_reg;
    logic [WIDTH-1:0] head_result;
    logic [WIDTH-1:0] tail_result;
    logic [3:0]       head_flags;
    logic [3:0]       tail_flags;
    logic             head_we;
    logic             tail_we;
    logic [3:0]       new_flags;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic             ovf;
    logic             in_hs;
    logic             out_hs;
    logic             load_head;
    logic             load_tail;
    logic             promote;

    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = (state != EMPTY) & bus.out_ready;

    // C and V come from a recomputed adder; Z and N always reflect the ULA result.
    always_comb begin
        b_eff = bus.in_b;
        cin   = 1'b0;
        arith = 1'b1;
        case (bus.in_opcode)
            5'b00000: ;
            5'b00001: cin = 1'b1;
            5'b00011: begin b_eff = '0;        cin = 1'b1; end
            5'b00100: b_eff = ~bus.in_b;
            5'b00101: begin b_eff = ~bus.in_b; cin = 1'b1; end
            5'b00110: b_eff = '1;
            default:  arith = 1'b0;
        endcase
        sum   = {1'b0, bus.in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        carry = arith & sum[WIDTH];
        ovf   = arith & (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
        new_flags = {(bus.in_result == '0), bus.in_result[WIDTH-1], carry, ovf};
    end

    always_comb begin
        state_d   = state;
        load_head = 1'b0;
        load_tail = 1'b0;
        promote   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && !out_hs) begin
                    state_d   = TWO;
                    load_tail = 1'b1;
                end else if (out_hs && !in_hs) begin
                    state_d = EMPTY;
                end else if (in_hs && out_hs) begin
                    load_head = 1'b1;
                end
            end
            TWO: begin
                if (out_hs) begin
                    state_d = ONE;
                    promote = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            flags_reg  <= 4'b0000;
        end else begin
            state      <= state_d;
            in_ready_q <= (int'(state_d) < DEPTH);
            if (out_hs && head_we) begin
                flags_reg <= head_flags;
            end
        end
    end

    // Head keeps its last contents once drained so the payload stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_result <= '0;
            head_flags  <= 4'b0000;
            head_we     <= 1'b0;
            tail_result <= '0;
            tail_flags  <= 4'b0000;
            tail_we     <= 1'b0;
        end else begin
            if (load_head) begin
                head_result <= bus.in_result;
                head_flags  <= new_flags;
                head_we     <= bus.in_flag_we;
            end else if (promote) begin
                head_result <= tail_result;
                head_flags  <= tail_flags;
                head_we     <= tail_we;
            end
            if (load_tail) begin
                tail_result <= bus.in_result;
                tail_flags  <= new_flags;
                tail_we     <= bus.in_flag_we;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state != EMPTY);
    assign bus.out_result = head_result;
    assign bus.out_flags  = head_flags;
    assign bus.flags_q    = flags_reg;
endmodule

// File: tb/tb_ula_flag_stage.sv
// Randomized scoreboard bench for ula_flag_stage: a driver pushes expected entries,
// a negedge monitor pops and compares, with flags predicted by signed/unsigned arithmetic.
module tb_ula_flag_stage;
    localparam int WIDTH = 32;
    localparam longint UMAX = 64'd4294967295;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;
    int pushed = 0;
    int popped = 0;
    int discarded = 0;
    int ready_mode = 1;
    logic [3:0] model_flags = 4'b0000;
    logic armed = 1'b0;
    logic [4:0] arith_ops [6] = '{5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110};

    ula_flag_stage_if #(.WIDTH(WIDTH)) bus ();

    ula_flag_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual === required) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    endtask

    // Flags from the arithmetic meaning of each opcode rather than from an adder.
    function automatic logic [3:0] refFlags(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic [31:0] res);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint s;
        bit c;
        bit v;
        bit arith;
        ua = 64'(a);
        ub = 64'(b);
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        s = 0;
        c = 1'b0;
        arith = 1'b1;
        case (op)
            5'b00000: begin s = sa + sb;     c = (ua + ub) > UMAX;     end
            5'b00001: begin s = sa + sb + 1; c = (ua + ub + 1) > UMAX; end
            5'b00011: begin s = sa + 1;      c = (ua == UMAX);         end
            5'b00100: begin s = sa - sb - 1; c = (ua > ub);            end
            5'b00101: begin s = sa - sb;     c = (ua >= ub);           end
            5'b00110: begin s = sa - 1;      c = (ua != 0);            end
            default:  arith = 1'b0;
        endcase
        v = arith && (s > SMAX || s < SMIN);
        return {res == 32'd0, $signed(res) < 0, c, v};
    endfunction

    task automatic setInputs(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                             input logic [31:0] res, input logic we);
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_opcode  = op;
        bus.in_result  = res;
        bus.in_flag_we = we;
        bus.in_valid   = 1'b1;
    endtask

    // Holds the current inputs until accepted, then records the expected entry.
    task automatic waitAccept();
        logic acc;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                e.result = bus.in_result;
                e.flags  = refFlags(bus.in_a, bus.in_b, bus.in_opcode, bus.in_result);
                e.we     = bus.in_flag_we;
                exp_q.push_back(e);
                pushed++;
                bus.in_valid = 1'b0;
                return;
            end
        end
        checks++;
        $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                 input logic [31:0] res, input logic we);
        setInputs(a, b, op, res, we);
        waitAccept();
    endtask

    task automatic randomEntry();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0] op;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        op = ($urandom_range(0, 1) == 1) ? arith_ops[$urandom_range(0, 5)] : 5'($urandom);
        case (op)
            5'b00000: res = a + b;
            5'b00001: res = a + b + 32'd1;
            5'b00011: res = a + 32'd1;
            5'b00100: res = a - b - 32'd1;
            5'b00101: res = a - b;
            5'b00110: res = a - 32'd1;
            default:  res = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        endcase
        applyStimulus(a, b, op, res, 1'($urandom_range(0, 1)));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) return;
        end
        checks++;
        $display("[TB] FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else armed <= 1'b1;
    end

    initial begin : ready_driver
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && armed) begin
                checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
                checkOutput("flags_q", 32'(bus.flags_q), 32'(model_flags));
                if (bus.out_valid && exp_q.size() != 0) begin
                    checkOutput("out_result", bus.out_result, exp_q[0].result);
                    checkOutput("out_flags", 32'(bus.out_flags), 32'(exp_q[0].flags));
                    if (bus.out_ready) begin
                        if (exp_q[0].we) model_flags = exp_q[0].flags;
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_opcode  = '0;
        bus.in_result  = '0;
        bus.in_flag_we = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_result", bus.out_result, 32'd0);
        checkOutput("reset_out_flags", 32'(bus.out_flags), 32'd0);
        checkOutput("reset_flags_q", 32'(bus.flags_q), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        $display("[TB] directed flag cases");
        applyStimulus(32'h7FFFFFFF, 32'd1, 5'b00000, 32'h80000000, 1'b1);
        waitDrain();
        checkOutput("add_ovf_flags_q", 32'(bus.flags_q), 32'b0101);
        applyStimulus(32'd0, 32'd0, 5'b00110, 32'hFFFFFFFF, 1'b1);
        waitDrain();
        checkOutput("deca_flags_q", 32'(bus.flags_q), 32'b0100);
        applyStimulus(32'h12345678, 32'h12345678, 5'b00101, 32'd0, 1'b1);
        waitDrain();
        checkOutput("sub_eq_flags_q", 32'(bus.flags_q), 32'b1010);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10001, 32'hFFFFFFFF, 1'b0);
        waitDrain();
        checkOutput("and_nowe_flags_q", 32'(bus.flags_q), 32'b1010);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10001, 32'hFFFFFFFF, 1'b1);
        waitDrain();
        checkOutput("and_we_flags_q", 32'(bus.flags_q), 32'b0100);

        $display("[TB] backpressure");
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(32'd1, 32'd2, 5'b00000, 32'h00000003, 1'b0);
        applyStimulus(32'd5, 32'd4, 5'b00101, 32'h00000001, 1'b0);
        setInputs(32'd9, 32'd9, 5'b00101, 32'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("held_head", bus.out_result, 32'h00000003);
        end
        ready_mode = 1;
        waitAccept();
        waitDrain();

        $display("[TB] simultaneous push/pop");
        for (int i = 0; i < 8; i++) randomEntry();
        waitDrain();

        $display("[TB] random traffic");
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            randomEntry();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        ready_mode = 1;
        waitDrain();

        $display("[TB] mid-stream reset");
        applyStimulus(32'h12345678, 32'h12345678, 5'b00101, 32'd0, 1'b1);
        waitDrain();
        checkOutput("pre_reset_flags_q", 32'(bus.flags_q), 32'b1010);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(32'h7FFFFFFF, 32'd1, 5'b00000, 32'h80000000, 1'b1);
        applyStimulus(32'd0, 32'd0, 5'b00110, 32'hFFFFFFFF, 1'b1);
        checkOutput("two_in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        discarded += exp_q.size();
        exp_q.delete();
        model_flags = 4'b0000;
        #1;
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_flags_q", 32'(bus.flags_q), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        ready_mode = 1;
        for (int i = 0; i < 6; i++) randomEntry();
        waitDrain();
        checkOutput("entry_count", 32'(popped + discarded), 32'(pushed));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ula_flag_stage.md
Name: ula_flag_stage

Overview:
- Execute-to-writeback stage directly downstream of the 32-bit ULA.
- Captures each ULA result together with its operands and 5-bit opcode, and derives the Z, N, C and V flags.
- Buffers up to two results in a skid buffer, with valid/ready handshakes on both sides.
- Holds the architectural flag register, which updates when a flag-writing result is accepted by writeback.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- DEPTH, 2, skid buffer entries; fixed at 2, no other value supported.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ULA result valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_a  input  WIDTH  operand A as presented to the ULA.
- in_b  input  WIDTH  operand B as presented to the ULA.
- in_opcode  input  5  ULA opcode.
- in_result  input  WIDTH  ULA output.
- in_flag_we  input  1  instruction writes the flag register.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts the head entry.
- out_result  output  WIDTH  head entry result.
- out_flags  output  4  head entry flags, ordered {Z,N,C,V}.
- flags_q  output  4  committed flag register, ordered {Z,N,C,V}.

Behaviour:
- Handshakes: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
- Reset (asynchronous, rst_n low):
  - Buffer empties.
  - out_valid=0, out_result=0, out_flags=0, flags_q=0.
  - in_ready=1 on the first edge after reset release.
- Flag derivation (combinational, applied on entry capture):
  - Z = (in_result==0).
  - N = in_result[31].
  - C and V depend on the opcode, with effective operand B' and carry-in as follows:
    - add 00000: B'=B, cin=0.
    - addinc 00001: B'=B, cin=1.
    - inca 00011: B'=0, cin=1.
    - subdec 00100: B'=~B, cin=0.
    - sub 00101: B'=~B, cin=1.
    - deca 00110: B'=32'hFFFFFFFF, cin=0.
  - For these six opcodes:
    - C = bit 32 of the 33-bit sum A+B'+cin.
    - V = (A[31]==B'[31]) & (sum[31]!=A[31]).
  - All other opcodes (shifts, logic, zeros, ones, undefined codes): C=0, V=0.
  - Z and N always come from in_result, never from a recomputed sum.
- Skid buffer FSM, states EMPTY, ONE, TWO:
  - EMPTY: input handshake -> ONE.
  - ONE:
    - input handshake without output handshake -> TWO.
    - output handshake without input handshake -> EMPTY.
    - both -> stay ONE, with the new entry replacing the head.
  - TWO:
    - output handshake -> ONE, with the second entry promoted to head.
    - in_ready=0, so no input is accepted.
  - out_valid=1 in ONE and TWO.
  - in_ready is registered; in_ready=0 exactly when the state is TWO.
- Latency: an entry accepted at edge k is presented on the out_* ports from after edge k. An entry accepted into an empty buffer can therefore complete its output handshake in the cycle following acceptance.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Flag commit: on an output handshake whose entry has flag_we=1, flags_q takes that entry's flags on the same edge. Entries with flag_we=0 leave flags_q unchanged.
- Payload stability: out_result and out_flags hold stable while out_valid=1 and out_ready=0. They keep their last value when the buffer is empty.
- in_valid while in_ready=0: ignored; the producer must hold its data.
- Reset asserted mid-operation: all entries discarded immediately and flags_q cleared; no partial commit.

Test Plan:
- Add overflow: A=0x7FFFFFFF, B=1, op 00000, result 0x80000000, flag_we=1 -> out_flags Z0 N1 C0 V1; flags_q=4'b0101 after the output handshake.
- Sub equal: A=B=0x12345678, op 00101, result 0 -> Z1 N0 C1 V0. Deca: A=0, op 00110, result 0xFFFFFFFF -> Z0 N1 C0 V0.
- Logic clears C/V: A=0xFFFFFFFF, B=0xFFFFFFFF, op 10001 (and), result 0xFFFFFFFF -> Z0 N1 C0 V0. Same inputs with flag_we=0 -> flags_q unchanged.
- Backpressure: out_ready=0 with three back-to-back inputs R1, R2, R3 -> in_ready drops after R2 and R3 is held. out_ready=1 -> outputs appear in order R1, R2, R3 with no loss.
- Simultaneous push/pop: in state ONE with in_valid=1 and out_ready=1 for 8 cycles -> state stays ONE and the 8 results emerge in order, one per cycle.
- Mid-stream reset: state TWO with flags_q=4'b1010, rst_n pulsed low -> immediately out_valid=0 and flags_q=0; in_ready=1 after release.
